uart_tx_fsm: RTL and testbench

//   Frame sequencer for the UART transmit path. Accepts a byte handshake and steps a

---
 rtl/uart_tx_pkg.sv | 35 +++
 rtl/uart_tx_fsm_if.sv | 34 +++
 rtl/uart_tx_parity_calc.sv | 20 ++
 rtl/uart_tx_fsm.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fsm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : uart_tx_pkg                                                     |
// | Purpose   : Shared encodings for the UART transmit frame sequencer: state   |
// |             encoding and line-select codes for the TX_OUT source mux.       |
// | Ports     : none (package)                                                  |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uart_tx_pkg;

  // State encoding
  localparam logic [2:0] IDLE_ENC   = 3'd0;
  localparam logic [2:0] START_ENC  = 3'd1;
  localparam logic [2:0] DATA_ENC   = 3'd2;
  localparam logic [2:0] PARITY_ENC = 3'd3;
  localparam logic [2:0] STOP_ENC   = 3'd4;
  localparam logic [2:0] STOP2_ENC  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = IDLE_ENC,
    START  = START_ENC,
    DATA   = DATA_ENC,
    PARITY = PARITY_ENC,
    STOP   = STOP_ENC,
    STOP2  = STOP2_ENC
  } state_t;

  // Line-select codes for the serial line source
  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_PAR   = 2'd2;
  localparam logic [1:0] SEL_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : uart_tx_fsm_if                                                  |
// | Purpose   : Byte handshake from the TX data source plus the serializer      |
// |             control/status signals of the UART transmit path.               |
// | Signals   : DATA_VALID, P_DATA[WIDTH], PAR_EN, PAR_TYP  (source -> fsm)     |
// |             ser_data, ser_done                          (serializer -> fsm) |
// |             ser_en, busy                                (fsm -> outside)    |
// | Modports  : master = source/serializer side, slave = frame sequencer        |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_tx_fsm_if #(
  parameter int WIDTH = 8
);
  logic             DATA_VALID;
  logic [WIDTH-1:0] P_DATA;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             ser_data;
  logic             ser_done;
  logic             ser_en;
  logic             busy;

  modport master (
    output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, busy
  );

  modport slave (
    input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_parity_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_tx_parity_calc                                             |
// | Purpose   : Combinational UART parity bit. Even parity for PAR_TYP=0,       |
// |             odd parity for PAR_TYP=1. Shared with the RX checker.           |
// | Ports     : P_DATA [WIDTH] in  - data byte                                  |
// |             PAR_TYP        in  - 0 even, 1 odd                              |
// |             par_bit        out - parity bit to transmit                     |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_TYP,
  output logic             par_bit
);
  assign par_bit = (^P_DATA) ^ PAR_TYP;
endmodule
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_tx_fsm                                                     |
// | Purpose   : UART transmit frame sequencer. Accepts a byte when idle, runs   |
// |             START -> DATA -> [PARITY] -> STOP (-> STOP2) -> IDLE, steps the |
// |             serializer during DATA and drives the registered line TX_OUT.   |
// | Ports     : CLK      in  - TX bit clock (one cycle per UART bit)            |
// |             RST      in  - asynchronous, active-low reset                   |
// |             bus      if  - uart_tx_fsm_if.slave (handshake + serializer)    |
// |             TX_OUT   out - registered serial line, idle high                |
// |             seq_err  out - sticky: ser_done disagreed with bit count        |
// | Config    : UART_TX_TWO_STOP_EN - adds a second stop bit (state STOP2)      |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_fsm_if.slave     bus,
  output logic             TX_OUT,
  output logic             seq_err
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_en_q;
  logic             par_bit_q;
  logic             par_bit_w;
  logic             accept;
  logic             last_bit;
  logic             ser_en_w;
  logic [1:0]       line_sel;
  logic             line_val;

  assign accept   = (state == IDLE) && bus.DATA_VALID;
  assign last_bit = (bit_cnt == LAST_BIT);

  // busy is decoded from the state register so the serializer load gate
  // never depends on the current-cycle DATA_VALID.
  assign bus.busy   = (state != IDLE);
  assign bus.ser_en = ser_en_w;

  uart_tx_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity (
    .P_DATA  (bus.P_DATA),
    .PAR_TYP (bus.PAR_TYP),
    .par_bit (par_bit_w)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    line_sel  = SEL_STOP;
    ser_en_w  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        line_sel  = SEL_START;
        state_nxt = DATA;
      end
      DATA: begin
        line_sel = SEL_DATA;
        ser_en_w = 1'b1;
        // bit_cnt alone decides when DATA ends; ser_done is only cross-checked.
        if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        line_sel  = SEL_PAR;
        state_nxt = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        state_nxt = STOP2;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: begin
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_val = 1'b1;
    case (line_sel)
      SEL_START: line_val = 1'b0;
      SEL_DATA:  line_val = bus.ser_data;
      SEL_PAR:   line_val = par_bit_q;
      default:   line_val = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= '0;
    end else if (state == DATA) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end else begin
      bit_cnt <= '0;
    end
  end

  // Frame configuration is captured at accept so later input changes cannot
  // disturb a frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= bus.PAR_EN;
      par_bit_q <= par_bit_w;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seq_err <= 1'b0;
    end else if ((state == DATA) && (bus.ser_done != last_bit)) begin
      seq_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) TX_OUT <= 1'b1;
    else      TX_OUT <= line_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_uart_tx_fsm                                                  |
// | Purpose   : Directed self-checking bench for uart_tx_fsm with a behavioural |
// |             LSB-first serializer. Samples are taken on the falling edge;    |
// |             sample j=0 is the first falling edge after the accept edge.     |
// | Ports     : none                                                            |
// | Config    : UART_TX_TWO_STOP_EN - selects two-stop-bit expectations         |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fsm;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic TX_OUT;
  logic seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_fsm_if #(.WIDTH(8)) bus ();

  uart_tx_fsm #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .TX_OUT  (TX_OUT),
    .seq_err (seq_err)
  );

  // Expected busy/TX windows (left-most bit = sample j=0)
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [15:0] EXP_BUSY_NP  = 16'hFFE0;
  localparam logic [15:0] EXP_BUSY_P   = 16'hFFF0;
  localparam logic [31:0] EXP_B2B_TX   = 32'hA038_07FF;
  localparam logic [31:0] EXP_B2B_BUSY = 32'hFFEF_FE00;
`else
  localparam logic [15:0] EXP_BUSY_NP  = 16'hFFC0;
  localparam logic [15:0] EXP_BUSY_P   = 16'hFFE0;
  localparam logic [31:0] EXP_B2B_TX   = 32'hA030_0FFF;
  localparam logic [31:0] EXP_B2B_BUSY = 32'hFFDF_F800;
`endif

  // Behavioural serializer: loads whenever busy=0 and DATA_VALID, shifts on ser_en.
  logic [7:0] sh;
  logic [3:0] cnt;
  logic       force_early = 1'b0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh  <= 8'h00;
      cnt <= 4'd0;
    end else begin
      if (!bus.busy && bus.DATA_VALID) sh <= bus.P_DATA;
      else if (bus.ser_en)             sh <= {1'b0, sh[7:1]};
      if (bus.ser_en) cnt <= cnt + 4'd1;
      else            cnt <= 4'd0;
    end
  end

  assign bus.ser_data = sh[0];
  assign bus.ser_done = bus.ser_en && ((cnt == 4'd7) || (force_early && (cnt == 4'd5)));

  // Presents one byte, then records 32 falling-edge samples of TX_OUT and busy.
  task automatic send_frame(
    input  logic [7:0] d,
    input  logic       pe,
    input  logic       pt,
    input  logic [7:0] d_after,
    input  logic       pe_after,
    input  logic       pt_after,
    input  int         dv_drop,
    output logic [31:0] tx_v,
    output logic [31:0] busy_v
  );
    @(negedge CLK);
    bus.DATA_VALID = 1'b1;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    for (int j = 0; j < 32; j++) begin
      @(negedge CLK);
      tx_v[31-j]   = TX_OUT;
      busy_v[31-j] = bus.busy;
      if (j == 0) begin
        bus.P_DATA  = d_after;
        bus.PAR_EN  = pe_after;
        bus.PAR_TYP = pt_after;
      end
      if (j == dv_drop) bus.DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_reset;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (TX_OUT !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", TX_OUT); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.ser_en !== 1'b0) begin n_fail++; $display("FAIL reset_ser_en: got %b expected 0", bus.ser_en); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (TX_OUT !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b expected 1", TX_OUT); end
  endtask

  task automatic test_no_parity;
    logic [31:0] tx_v, busy_v;
    send_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0, tx_v, busy_v);
    n_checks++;
    if (tx_v[31:16] !== 16'hA97F) begin n_fail++; $display("FAIL np_tx: got %h expected %h", tx_v[31:16], 16'hA97F); end
    n_checks++;
    if (busy_v[31:16] !== EXP_BUSY_NP) begin n_fail++; $display("FAIL np_busy: got %h expected %h", busy_v[31:16], EXP_BUSY_NP); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL np_seq_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_parity;
    logic [31:0] tx_v, busy_v;
    // Even parity of 0xA5 is 0; inputs are scrambled right after accept.
    send_frame(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, tx_v, busy_v);
    n_checks++;
    if (tx_v[31:16] !== 16'hA95F) begin n_fail++; $display("FAIL par_even_tx: got %h expected %h", tx_v[31:16], 16'hA95F); end
    n_checks++;
    if (busy_v[31:16] !== EXP_BUSY_P) begin n_fail++; $display("FAIL par_even_busy: got %h expected %h", busy_v[31:16], EXP_BUSY_P); end
    // Odd parity of 0xA5 is 1.
    send_frame(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 0, tx_v, busy_v);
    n_checks++;
    if (tx_v[31:16] !== 16'hA97F) begin n_fail++; $display("FAIL par_odd_tx: got %h expected %h", tx_v[31:16], 16'hA97F); end
    n_checks++;
    if (busy_v[31:16] !== EXP_BUSY_P) begin n_fail++; $display("FAIL par_odd_busy: got %h expected %h", busy_v[31:16], EXP_BUSY_P); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tx_v, busy_v;
    // DATA_VALID stays high until frame two is under way; 0x80 is presented while busy.
    send_frame(8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 13, tx_v, busy_v);
    n_checks++;
    if (tx_v !== EXP_B2B_TX) begin n_fail++; $display("FAIL b2b_tx: got %h expected %h", tx_v, EXP_B2B_TX); end
    n_checks++;
    if (busy_v !== EXP_B2B_BUSY) begin n_fail++; $display("FAIL b2b_busy: got %h expected %h", busy_v, EXP_B2B_BUSY); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] tx_v, busy_v;
    @(negedge CLK);
    bus.DATA_VALID = 1'b1;
    bus.P_DATA     = 8'hF0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      @(negedge CLK);
      if (j == 0) bus.DATA_VALID = 1'b0;
    end
    // Fourth DATA cycle: line carries bit 2 of 0xF0.
    n_checks++;
    if (TX_OUT !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tx: got %b expected 0", TX_OUT); end
    RST = 1'b0;
    #1;
    n_checks++;
    if (TX_OUT !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: got %b expected 1", TX_OUT); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    @(negedge CLK);
    RST = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, tx_v, busy_v);
    n_checks++;
    if (tx_v[31:16] !== 16'h8F3F) begin n_fail++; $display("FAIL mid_after_tx: got %h expected %h", tx_v[31:16], 16'h8F3F); end
    n_checks++;
    if (busy_v[31:16] !== EXP_BUSY_NP) begin n_fail++; $display("FAIL mid_after_busy: got %h expected %h", busy_v[31:16], EXP_BUSY_NP); end
  endtask

  task automatic test_seq_err;
    logic [31:0] tx_v, busy_v;
    force_early = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 0, tx_v, busy_v);
    force_early = 1'b0;
    n_checks++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seqerr_set: got %b expected 1", seq_err); end
    n_checks++;
    if (tx_v[31:16] !== 16'hA97F) begin n_fail++; $display("FAIL seqerr_tx: got %h expected %h", tx_v[31:16], 16'hA97F); end
    n_checks++;
    if (busy_v[31:16] !== EXP_BUSY_NP) begin n_fail++; $display("FAIL seqerr_busy: got %h expected %h", busy_v[31:16], EXP_BUSY_NP); end
    send_frame(8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 0, tx_v, busy_v);
    n_checks++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seqerr_sticky: got %b expected 1", seq_err); end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seqerr_clear: got %b expected 0", seq_err); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

`ifdef UART_TX_TWO_STOP_EN
  task automatic test_two_stop;
    logic [31:0] tx_v, busy_v;
    send_frame(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, tx_v, busy_v);
    n_checks++;
    if (tx_v[31:16] !== 16'h803F) begin n_fail++; $display("FAIL two_stop_tx: got %h expected %h", tx_v[31:16], 16'h803F); end
    n_checks++;
    if (busy_v[31:16] !== 16'hFFE0) begin n_fail++; $display("FAIL two_stop_busy: got %h expected %h", busy_v[31:16], 16'hFFE0); end
  endtask
`endif

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_seq_err();
`ifdef UART_TX_TWO_STOP_EN
    test_two_stop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
